// File: rtl/io_int_pkg.sv
// io_int_pkg: register offsets and bit positions shared by the I/O interrupt controller.
package io_int_pkg;
  typedef enum logic [1:0] {OFS_STATUS, OFS_MASK, OFS_CTRL, OFS_RELOAD} reg_ofs_e;
  localparam int CTRL_GIE_BIT = 0;
  localparam int TIMER_SRC = 0;
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: two-flop synchronizer plus history flop yielding a one-cycle rise pulse per bit.
module irq_sync_edge #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] s1_q, s2_q, h_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      h_q  <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      h_q  <= s2_q;
    end
  assign rise_o = s2_q & ~h_q;
endmodule

// File: rtl/io_int_controller.sv
// io_int_controller: memory-mapped status/mask/ctrl/reload registers and a masked interrupt request.
module io_int_controller
  import io_int_pkg::*;
#(
  parameter logic [7:0] BASE_ID = 8'h40,
  parameter int PRESCALE = 1000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  input  logic [6:0] IRQ_IN,
  output logic [7:0] IN_PORT,
  output logic       INTERRUPT
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] pend_q, pend_d, mask_q, mask_d, ctrl_q, ctrl_d, reload_q, reload_d, tcnt_q, tcnt_d;
  logic [7:0] ofs, set, w1c;
  logic [6:0] rise;
  logic hit, wr, tick, run, int_q;
  irq_sync_edge #(.W(7)) u_sync (
    .clk_i(CLK),
    .rst_ni(RESET_N),
    .d_i(IRQ_IN),
    .rise_o(rise)
  );
  assign ofs  = PORT_ID - BASE_ID;
  assign hit  = ofs[7:2] == 6'd0;
  assign wr   = IO_STRB & hit;
  assign tick = presc_q == PW'(PRESCALE - 1);
  assign run  = tick && reload_q != 8'd0;
  always_comb begin
    set = {rise, 1'b0};
    set[TIMER_SRC] = run && tcnt_q == 8'd1;
    w1c = (wr && ofs[1:0] == OFS_STATUS) ? OUT_PORT : 8'h00;
    pend_d = (pend_q & ~w1c) | set;
    mask_d = (wr && ofs[1:0] == OFS_MASK) ? OUT_PORT : mask_q;
    ctrl_d = (wr && ofs[1:0] == OFS_CTRL) ? OUT_PORT : ctrl_q;
    reload_d = (wr && ofs[1:0] == OFS_RELOAD) ? OUT_PORT : reload_q;
    // A reload write restarts the period from a clean prescaler phase.
    presc_d = (wr && ofs[1:0] == OFS_RELOAD) || tick ? '0 : presc_q + 1'b1;
    tcnt_d = (wr && ofs[1:0] == OFS_RELOAD) ? OUT_PORT :
             !run ? tcnt_q : tcnt_q == 8'd1 ? reload_q : tcnt_q - 8'd1;
  end
  always_ff @(posedge CLK)
    if (!RESET_N) begin
      presc_q  <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      reload_q <= '0;
      tcnt_q   <= '0;
      int_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      tcnt_q   <= tcnt_d;
      int_q    <= ctrl_q[CTRL_GIE_BIT] & |(pend_q & mask_q);
    end
  assign IN_PORT = !hit ? 8'h00 :
                   ofs[1:0] == OFS_STATUS ? pend_q :
                   ofs[1:0] == OFS_MASK ? mask_q :
                   ofs[1:0] == OFS_CTRL ? ctrl_q : reload_q;
  assign INTERRUPT = int_q;
endmodule

// File: tb/tb_io_int_controller.sv
// tb_io_int_controller: directed scenarios plus randomized traffic against an event-level reference model.
module tb_io_int_controller;
  localparam logic [7:0] BASE = 8'h40;
  localparam int P = 4;
  logic clk = 0, rst_n = 0, strb = 0, intr;
  logic [7:0] port = 0, out = 0, in_port;
  logic [6:0] irq = 0;
  logic [7:0] m_pend = 0, m_mask = 0, m_ctrl = 0, m_reload = 0;
  logic m_int = 0;
  logic [6:0] p1 = 0, p2 = 0, p3 = 0;
  int cyc = 0, next_evt = 0, n_chk = 0, n_fail = 0;
  io_int_controller #(.BASE_ID(BASE), .PRESCALE(P)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .PORT_ID(port),
    .OUT_PORT(out),
    .IO_STRB(strb),
    .IRQ_IN(irq),
    .IN_PORT(in_port),
    .INTERRUPT(intr)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] o;
    o = a - BASE;
    return o == 0 ? m_pend : o == 1 ? m_mask : o == 2 ? m_ctrl : o == 3 ? m_reload : 8'h00;
  endfunction
  // Reference: an external event lands two edges after the first high sample; the timer fires every RELOAD*P edges after a RELOAD write.
  task automatic step();
    logic [7:0] set, w1c, o;
    logic ni;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_ctrl = 0; m_reload = 0; m_int = 0;
      p1 = 0; p2 = 0; p3 = 0;
    end else begin
      ni = m_ctrl[0] & |(m_pend & m_mask);
      set = {p2 & ~p3, 1'b0};
      if (m_reload != 0 && cyc == next_evt) begin
        set[0] = 1'b1;
        next_evt = cyc + int'(m_reload) * P;
      end
      w1c = 0;
      o = port - BASE;
      if (strb && o < 4) begin
        if (o == 0) w1c = out;
        if (o == 1) m_mask = out;
        if (o == 2) m_ctrl = out;
        if (o == 3) begin
          m_reload = out;
          next_evt = cyc + int'(out) * P;
        end
      end
      m_pend = (m_pend & ~w1c) | set;
      m_int = ni;
      p3 = p2; p2 = p1; p1 = irq;
    end
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port = a; out = d; strb = 1;
    step();
    strb = 0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    port = a; strb = 0;
    #1;
    v = in_port;
  endtask
  task automatic test_reset();
    logic [7:0] v;
    rst_n = 0; irq = 7'h7F;
    repeat (3) step();
    for (int a = 0; a < 4; a++) begin
      rd(BASE + 8'(a), v);
      n_chk++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_read%0d got %h want 00", a, v); end
    end
    n_chk++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_int got %b want 0", intr); end
    rst_n = 1;
    step(); step();
    rd(BASE, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status_early got %h want 00", v); end
    step();
    rd(BASE, v);
    n_chk++;
    if (v !== 8'hFE) begin n_fail++; $display("FAIL reset_status_fe got %h want fe", v); end
  endtask
  task automatic test_basic();
    logic [7:0] v;
    irq = 0;
    repeat (4) step();
    wr(BASE, 8'hFF); wr(BASE + 1, 8'h04); wr(BASE + 2, 8'h01);
    irq = 7'h02;
    step(); step(); step();
    n_chk++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL basic_int_early got %b want 0", intr); end
    step();
    n_chk++;
    if (intr !== 1'b1) begin n_fail++; $display("FAIL basic_int_k3 got %b want 1", intr); end
    irq = 0;
    wr(BASE, 8'h04);
    step();
    n_chk++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL basic_int_clear got %b want 0", intr); end
    rd(BASE, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL basic_status got %h want 00", v); end
  endtask
  task automatic test_mask();
    logic [7:0] v;
    wr(BASE + 1, 8'h00);
    irq = 7'h40;
    repeat (4) step();
    irq = 0;
    repeat (4) step();
    rd(BASE, v);
    n_chk++;
    if (v !== 8'h80) begin n_fail++; $display("FAIL mask_status got %h want 80", v); end
    n_chk++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL mask_int_masked got %b want 0", intr); end
    wr(BASE + 1, 8'h80);
    step();
    n_chk++;
    if (intr !== 1'b1) begin n_fail++; $display("FAIL mask_int_unmask got %b want 1", intr); end
    wr(BASE + 2, 8'h00);
    step();
    n_chk++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL mask_gie_clear got %b want 0", intr); end
    wr(BASE, 8'h80); wr(BASE + 2, 8'h01);
  endtask
  task automatic test_simul();
    logic [7:0] v;
    irq = 7'h08;
    step(); step();
    wr(BASE, 8'h10);
    irq = 0;
    rd(BASE, v);
    n_chk++;
    if (v !== 8'h10) begin n_fail++; $display("FAIL simul_status got %h want 10", v); end
    repeat (3) step();
    wr(BASE, 8'h10);
  endtask
  task automatic test_timer();
    logic [7:0] v;
    int cnt;
    wr(BASE + 3, 8'd3);
    for (int i = 1; i <= 24; i++) begin
      if (i == 13) wr(BASE, 8'h01); else step();
      rd(BASE, v);
      n_chk++;
      if (v[0] !== (i == 12 || i == 24)) begin n_fail++; $display("FAIL timer_period i=%0d got %b want %b", i, v[0], i == 12 || i == 24); end
    end
    wr(BASE + 3, 8'd0); wr(BASE, 8'h01);
    cnt = 0;
    repeat (100) begin
      step();
      rd(BASE, v);
      if (v[0]) cnt++;
    end
    n_chk++;
    if (cnt !== 0) begin n_fail++; $display("FAIL timer_disabled got %0d sets want 0", cnt); end
    wr(BASE + 3, 8'd3);
    repeat (5) step();
    wr(BASE + 3, 8'd3);
    for (int i = 1; i <= 12; i++) begin
      step();
      rd(BASE, v);
      n_chk++;
      if (v[0] !== (i == 12)) begin n_fail++; $display("FAIL timer_rewrite i=%0d got %b want %b", i, v[0], i == 12); end
    end
    rd(BASE + 3, v);
    n_chk++;
    if (v !== 8'h03) begin n_fail++; $display("FAIL timer_reload_rd got %h want 03", v); end
    wr(BASE + 3, 8'd0); wr(BASE, 8'h01);
  endtask
  task automatic test_decode();
    logic [7:0] v, snap[4];
    for (int a = 0; a < 4; a++) rd(BASE + 8'(a), snap[a]);
    wr(BASE + 4, 8'hFF);
    for (int a = 0; a < 4; a++) begin
      rd(BASE + 8'(a), v);
      n_chk++;
      if (v !== snap[a] || v !== m_read(BASE + 8'(a))) begin n_fail++; $display("FAIL decode_reg%0d got %h want %h", a, v, m_read(BASE + 8'(a))); end
    end
    rd(BASE + 4, v);
    n_chk++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL decode_miss got %h want 00", v); end
    wr(BASE + 2, 8'hA5);
    rd(BASE + 2, v);
    n_chk++;
    if (v !== 8'hA5) begin n_fail++; $display("FAIL decode_ctrl got %h want a5", v); end
  endtask
  task automatic test_random();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    repeat (3000) begin
      for (int b = 0; b < 7; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      port = BASE - 8'd1 + 8'($urandom_range(5));
      strb = $urandom_range(3) == 0;
      out = port == BASE + 3 ? 8'($urandom_range(7)) : 8'($urandom);
      #1;
      n_chk++;
      if (in_port !== m_read(port)) begin n_fail++; $display("FAIL rand_read cyc=%0d port=%h got %h want %h", cyc, port, in_port, m_read(port)); end
      n_chk++;
      if (intr !== m_int) begin n_fail++; $display("FAIL rand_int cyc=%0d got %b want %b", cyc, intr, m_int); end
      step();
    end
    strb = 0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_simul();
    test_timer();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
